fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch with a decode handshake and branch/jump redirect.
// Define FETCH_PERF_CNT_EN to add the fetch_count / redirect_count performance counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        nrst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        resolve_valid,
    input  logic        branch,
    input  logic        mux_branch_jump,
    input  logic        mux_pc_branch,
    input  logic        alu_zero,
    input  logic [31:0] resolve_pc,
    input  logic [31:0] branch_offset,
    input  logic [25:0] jump_index,
    output logic        redirect
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [15:0] redirect_count
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        WAIT_DEC = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        discard;

    logic        beq_taken;
    logic        bne_taken;
    logic        jump_taken;
    logic        take;
    logic        handshake;
    logic [31:0] resolve_pc4;
    logic [31:0] target;

    assign beq_taken   = branch & mux_pc_branch & mux_branch_jump & alu_zero;
    assign bne_taken   = ~branch & mux_pc_branch & ~mux_branch_jump & ~alu_zero;
    assign jump_taken  = ~branch & ~mux_pc_branch & ~mux_branch_jump;
    assign take        = resolve_valid & (beq_taken | bne_taken | jump_taken) & (state != IDLE);
    assign handshake   = instr_valid & instr_ready;
    assign resolve_pc4 = resolve_pc + 32'd4;
    assign target      = jump_taken ? {resolve_pc4[31:28], jump_index, 2'b00}
                                    : resolve_pc4 + (branch_offset << 2);
    assign opcode      = instr[31:26];

    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            redirect    <= 1'b0;
            discard     <= 1'b0;
        end else begin
            redirect <= take;
            if (take)
                pc <= target;

            case (state)
                IDLE: begin
                    state     <= FETCH;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                end

                FETCH: begin
                    if (imem_ack) begin
                        // A word returned after (or with) a redirect belongs to the dead path.
                        if (take || discard) begin
                            discard   <= 1'b0;
                            imem_addr <= take ? target : pc;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= imem_addr;
                            instr_valid <= 1'b1;
                            pc          <= pc + 32'd4;
                            imem_req    <= 1'b0;
                            state       <= WAIT_DEC;
                        end
                    end else if (take) begin
                        discard <= 1'b1;
                    end
                end

                WAIT_DEC: begin
                    if (take || handshake) begin
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        imem_addr   <= take ? target : pc;
                        state       <= FETCH;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fetch_count    <= '0;
            redirect_count <= '0;
        end else begin
            if (handshake)
                fetch_count <= fetch_count + 32'd1;
            if (take)
                redirect_count <= redirect_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a transaction-level model (next expected decode address).
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        nrst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        instr_ready;
    logic        resolve_valid;
    logic        branch;
    logic        mux_branch_jump;
    logic        mux_pc_branch;
    logic        alu_zero;
    logic [31:0] resolve_pc;
    logic [31:0] branch_offset;
    logic [25:0] jump_index;
    logic        redirect;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [15:0] redirect_count;
`endif

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .opcode         (opcode),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .resolve_valid  (resolve_valid),
        .branch         (branch),
        .mux_branch_jump(mux_branch_jump),
        .mux_pc_branch  (mux_pc_branch),
        .alu_zero       (alu_zero),
        .resolve_pc     (resolve_pc),
        .branch_offset  (branch_offset),
        .jump_index     (jump_index),
        .redirect       (redirect)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count),
        .redirect_count (redirect_count)
`endif
    );

    always #5 clk = ~clk;

    // Memory image: deterministic scramble of the address so every word is distinct.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a ^ 32'hA5A5_5A5A) * 32'h9E37_79B1) + {a[5:0], a[31:6]};
    endfunction

    function automatic logic taken_f(input logic br, mbj, mpb, z);
        return (br && mpb && mbj && z) || (!br && mpb && !mbj && !z) || (!br && !mpb && !mbj);
    endfunction

    function automatic logic [31:0] target_f(input logic br, mbj, mpb,
                                             input logic [31:0] rpc, off,
                                             input logic [25:0] idx);
        logic [31:0] seq;
        seq = rpc + 32'd4;
        if (!br && !mpb && !mbj)
            return {seq[31:28], idx, 2'b00};
        return seq + off * 32'd4;
    endfunction

    task automatic drive_resolve(input logic br, mbj, mpb, z,
                                 input logic [31:0] rpc, off, input logic [25:0] idx);
        resolve_valid   = 1'b1;
        branch          = br;
        mux_branch_jump = mbj;
        mux_pc_branch   = mpb;
        alu_zero        = z;
        resolve_pc      = rpc;
        branch_offset   = off;
        jump_index      = idx;
    endtask

    task automatic clear_resolve();
        resolve_valid   = 1'b0;
        branch          = 1'b0;
        mux_branch_jump = 1'b0;
        mux_pc_branch   = 1'b0;
        alu_zero        = 1'b0;
        resolve_pc      = '0;
        branch_offset   = '0;
        jump_index      = '0;
    endtask

    task automatic test_reset();
        logic [98:0] exp_v;
        nrst        = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        clear_resolve();
        repeat (2) @(negedge clk);
        exp_v = {1'b0, RESET_PC, 32'h0, 32'h0, 1'b0, 1'b0};
        checks++;
        if ({imem_req, imem_addr, instr, instr_pc, instr_valid, redirect} !== exp_v) begin
            errors++;
            $display("FAIL reset_values got %h exp %h",
                     {imem_req, imem_addr, instr, instr_pc, instr_valid, redirect}, exp_v);
        end
        nrst = 1'b1;
        @(negedge clk);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin
            errors++;
            $display("FAIL first_request got %h exp %h", {imem_req, imem_addr}, {1'b1, RESET_PC});
        end
    endtask

    // Sequential fetch 0,4,8 with one-cycle memory and decode always ready.
    task automatic test_sequential();
        logic [31:0] w;
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({imem_req, imem_addr} !== {1'b1, RESET_PC + 32'(4 * k)}) begin
                errors++;
                $display("FAIL seq_addr%0d got %h exp %h", k, {imem_req, imem_addr},
                         {1'b1, RESET_PC + 32'(4 * k)});
            end
            w = mem_word(RESET_PC + 32'(4 * k));
            imem_ack   = 1'b1;
            imem_rdata = w;
            @(negedge clk);
            imem_ack = 1'b0;
            checks++;
            if ({imem_req, instr_valid, instr_pc, instr, opcode} !==
                {1'b0, 1'b1, RESET_PC + 32'(4 * k), w, w[31:26]}) begin
                errors++;
                $display("FAIL seq_deliver%0d got %h exp %h", k,
                         {imem_req, instr_valid, instr_pc, instr, opcode},
                         {1'b0, 1'b1, RESET_PC + 32'(4 * k), w, w[31:26]});
            end
            @(negedge clk);
        end
    endtask

    // Decode stalls for 5 cycles: instruction held, no new request.
    task automatic test_stall();
        logic [31:0] w;
        w = mem_word(32'hC);
        instr_ready = 1'b0;
        imem_ack    = 1'b1;
        imem_rdata  = w;
        @(negedge clk);
        imem_ack = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({instr_valid, instr, instr_pc, imem_req} !== {1'b1, w, 32'hC, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold%0d got %h exp %h", c,
                         {instr_valid, instr, instr_pc, imem_req}, {1'b1, w, 32'hC, 1'b0});
            end
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin
            errors++;
            $display("FAIL stall_release got %h exp %h", {imem_req, imem_addr}, {1'b1, 32'h10});
        end
    endtask

    // BEQ taken in WAIT_DEC flushes and redirects; not-taken leaves the instruction alone.
    task automatic test_beq();
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h10);
        @(negedge clk);
        imem_ack = 1'b0;
        drive_resolve(1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'hFFFF_FFFE, 26'h0);
        @(negedge clk);
        clear_resolve();
        checks++;
        if ({redirect, instr_valid, imem_req, imem_addr} !== {1'b1, 1'b0, 1'b1, 32'hC}) begin
            errors++;
            $display("FAIL beq_taken got %h exp %h", {redirect, instr_valid, imem_req, imem_addr},
                     {1'b1, 1'b0, 1'b1, 32'hC});
        end
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'hC);
        @(negedge clk);
        imem_ack = 1'b0;
        checks++;
        if (redirect !== 1'b0) begin
            errors++;
            $display("FAIL beq_pulse_width got %b exp 0", redirect);
        end
        drive_resolve(1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'hFFFF_FFFE, 26'h0);
        @(negedge clk);
        clear_resolve();
        checks++;
        if ({redirect, instr_valid, instr_pc} !== {1'b0, 1'b1, 32'hC}) begin
            errors++;
            $display("FAIL beq_not_taken got %h exp %h", {redirect, instr_valid, instr_pc},
                     {1'b0, 1'b1, 32'hC});
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
    endtask

    // Jump while the fetch at 0x10 is still outstanding.
    task automatic test_jump_unacked();
        drive_resolve(1'b0, 1'b0, 1'b0, 1'b0, 32'h4000_0010, 32'h0, 26'h10);
        @(negedge clk);
        clear_resolve();
        checks++;
        if ({redirect, imem_req, imem_addr} !== {1'b1, 1'b1, 32'h10}) begin
            errors++;
            $display("FAIL jump_hold_req got %h exp %h", {redirect, imem_req, imem_addr},
                     {1'b1, 1'b1, 32'h10});
        end
        imem_ack    = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        instr_ready = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++;
        if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h4000_0040}) begin
            errors++;
            $display("FAIL jump_discard got %h exp %h", {instr_valid, imem_req, imem_addr},
                     {1'b0, 1'b1, 32'h4000_0040});
        end
    endtask

    // BNE taken with a simultaneous ack, then reset while a discard is pending.
    task automatic test_bne_ack_and_reset();
        logic [31:0] w;
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        drive_resolve(1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h3, 26'h0);
        @(negedge clk);
        imem_ack = 1'b0;
        clear_resolve();
        checks++;
        if ({instr_valid, redirect, imem_req, imem_addr} !== {1'b0, 1'b1, 1'b1, 32'h110}) begin
            errors++;
            $display("FAIL bne_ack got %h exp %h", {instr_valid, redirect, imem_req, imem_addr},
                     {1'b0, 1'b1, 1'b1, 32'h110});
        end
        drive_resolve(1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 26'h80);
        @(negedge clk);
        clear_resolve();
        #2 nrst = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr, instr, instr_pc, instr_valid, redirect} !==
            {1'b0, RESET_PC, 32'h0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got %h exp %h",
                     {imem_req, imem_addr, instr, instr_pc, instr_valid, redirect},
                     {1'b0, RESET_PC, 32'h0, 32'h0, 1'b0, 1'b0});
        end
        @(negedge clk);
        nrst       = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++;
        if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, RESET_PC}) begin
            errors++;
            $display("FAIL late_ack_idle got %h exp %h", {instr_valid, imem_req, imem_addr},
                     {1'b0, 1'b1, RESET_PC});
        end
        w          = mem_word(RESET_PC);
        imem_ack   = 1'b1;
        imem_rdata = w;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, RESET_PC, w}) begin
            errors++;
            $display("FAIL restart_deliver got %h exp %h", {instr_valid, instr_pc, instr},
                     {1'b1, RESET_PC, w});
        end
        instr_ready = 1'b1;
        @(negedge clk);
    endtask

    // Jump to the top word, then the sequential pc wraps to zero.
    task automatic test_wrap();
        imem_ack   = 1'b1;
        imem_rdata = 32'h0BAD_F00D;
        drive_resolve(1'b0, 1'b0, 1'b0, 1'b0, 32'hF000_0000, 32'h0, 26'h3FF_FFFF);
        @(negedge clk);
        clear_resolve();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL wrap_target got %h exp %h", {imem_req, imem_addr}, {1'b1, 32'hFFFF_FFFC});
        end
        imem_rdata = mem_word(32'hFFFF_FFFC);
        @(negedge clk);
        imem_ack = 1'b0;
        checks++;
        if ({instr_valid, instr_pc} !== {1'b1, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL wrap_deliver got %h exp %h", {instr_valid, instr_pc}, {1'b1, 32'hFFFF_FFFC});
        end
        @(negedge clk);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL wrap_zero got %h exp %h", {imem_req, imem_addr}, {1'b1, 32'h0});
        end
    endtask

    // Random memory latency, decode backpressure and resolutions; the model only
    // tracks which address decode must see next and whether a redirect is due.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] ew;
        logic [31:0] held_addr;
        logic        outstanding;
        logic        exp_redir;
        logic        tk;
        logic        hs;
        int          delivered;
        exp_pc      = 32'h0;
        outstanding = 1'b0;
        exp_redir   = 1'b0;
        delivered   = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checks++;
            if (redirect !== exp_redir) begin
                errors++;
                $display("FAIL rnd_redirect cyc %0d got %b exp %b", cyc, redirect, exp_redir);
            end
            if (imem_req) begin
                if (outstanding) begin
                    checks++;
                    if (imem_addr !== held_addr) begin
                        errors++;
                        $display("FAIL rnd_addr_stable cyc %0d got %h exp %h", cyc, imem_addr, held_addr);
                    end
                end
                held_addr   = imem_addr;
                outstanding = 1'b1;
            end else begin
                outstanding = 1'b0;
            end
            if (instr_valid) begin
                ew = mem_word(exp_pc);
                checks++;
                if ({instr_pc, instr, opcode} !== {exp_pc, ew, ew[31:26]}) begin
                    errors++;
                    $display("FAIL rnd_deliver cyc %0d got %h exp %h", cyc,
                             {instr_pc, instr, opcode}, {exp_pc, ew, ew[31:26]});
                end
            end

            imem_ack    = imem_req && ($urandom_range(0, 2) == 0);
            imem_rdata  = imem_ack ? mem_word(imem_addr) : $urandom;
            instr_ready = $urandom_range(0, 1) == 1;
            if (imem_ack)
                outstanding = 1'b0;
            clear_resolve();
            if ($urandom_range(0, 5) == 0)
                drive_resolve(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                              $urandom & 32'hFFFF_FFFC, 32'($signed($urandom_range(0, 64)) - 32),
                              26'($urandom));
            hs = instr_valid && instr_ready;
            tk = resolve_valid && taken_f(branch, mux_branch_jump, mux_pc_branch, alu_zero);
            if (hs)
                delivered++;
            if (tk)
                exp_pc = target_f(branch, mux_branch_jump, mux_pc_branch, resolve_pc,
                                  branch_offset, jump_index);
            else if (hs)
                exp_pc = exp_pc + 32'd4;
            exp_redir = tk;
            @(negedge clk);
        end
        clear_resolve();
        imem_ack = 1'b0;
        checks++;
        if (delivered < 100) begin
            errors++;
            $display("FAIL rnd_progress got %0d exp >= 100", delivered);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_beq();
        test_jump_unacked();
        test_bne_ack_and_reset();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
